trg_byte_sched: RTL

Two-requester scheduler for the trigger bank: arbitrates between two byte sources, captures the granted byte and serialises it LSB-first onto the shared trigger data/strobe lines at a fixed bit rate. It sits between the byte producers and the `trigger1` instances. It owns `active`, which the rest of the design watches to know the trigger bank is busy.

---
 rtl/trg_byte_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/trg_byte_sched.sv
// trg_byte_sched: two-requester round-robin scheduler that captures the granted
// byte and serialises it LSB-first onto the trigger data/strobe lines.
// Optional feature macro: TRG_SCHED_PARITY_EN appends an even-parity bit period
// after the MSB. Without it only DATA_W bit periods are sent.
module trg_byte_sched #(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic [DATA_W-1:0] i_byte0,
  input  logic              i_req1,
  input  logic [DATA_W-1:0] i_byte1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_trg_d,
  output logic              o_trg_en,
  output logic              o_active,
  output logic              o_done,
  output logic              o_gnt
);

`ifdef TRG_SCHED_PARITY_EN
  // Data bits plus one trailing parity bit travel through the shift register.
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif

  // Cycle counter needs at least one bit even when BIT_CYC is 1.
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int BW = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [NB-1:0]   r_sr;
  logic [CW-1:0]   r_cyc;
  logic [BW-1:0]   r_bit;
  logic            r_last;

  logic              w_win_valid;
  logic              w_win;
  logic [DATA_W-1:0] w_sel_byte;
  logic [NB-1:0]     w_load;
  logic [NB-1:0]     w_shifted;
  logic [BW-1:0]     w_bit_next;
  logic              w_period_end;
  logic              w_last_bit;

  // Round-robin pick (tie goes to the requester that did not win last) and
  // next-value helpers for the shift datapath; feeds registers only.
  always_comb begin
    w_win_valid  = i_req0 | i_req1;
    w_win        = (i_req0 & i_req1) ? ~r_last : i_req1;
    w_sel_byte   = w_win ? i_byte1 : i_byte0;
`ifdef TRG_SCHED_PARITY_EN
    w_load       = {^w_sel_byte, w_sel_byte};
`else
    w_load       = w_sel_byte;
`endif
    w_shifted    = r_sr >> 1;
    w_bit_next   = r_bit + 1'b1;
    w_period_end = (r_cyc == CW'(BIT_CYC - 1));
    w_last_bit   = (w_bit_next == BW'(NB));
  end

  // Scheduler FSM with registered outputs; every output reflects the state
  // being entered so the first bit appears together with the ack.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_sr     <= '0;
      r_cyc    <= '0;
      r_bit    <= '0;
      r_last   <= 1'b1;
      o_ack0   <= 1'b0;
      o_ack1   <= 1'b0;
      o_trg_d  <= 1'b0;
      o_trg_en <= 1'b0;
      o_active <= 1'b0;
      o_done   <= 1'b0;
      o_gnt    <= 1'b0;
    end else begin
      // Pulsed outputs default low every cycle.
      o_ack0   <= 1'b0;
      o_ack1   <= 1'b0;
      o_done   <= 1'b0;
      o_trg_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_active <= 1'b0;
          o_trg_d  <= 1'b0;
          if (w_win_valid) begin
            r_sr     <= w_load;
            r_cyc    <= '0;
            r_bit    <= '0;
            r_last   <= w_win;
            o_gnt    <= w_win;
            o_ack0   <= ~w_win;
            o_ack1   <= w_win;
            o_active <= 1'b1;
            o_trg_en <= 1'b1;
            o_trg_d  <= w_load[0];
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_period_end) begin
            r_cyc <= '0;
            r_sr  <= w_shifted;
            r_bit <= w_bit_next;
            if (w_last_bit) begin
              r_state  <= S_DONE;
              o_done   <= 1'b1;
              o_active <= 1'b0;
              o_trg_d  <= 1'b0;
            end else begin
              o_trg_en <= 1'b1;
              o_trg_d  <= w_shifted[0];
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
